fpcmp_sched: RTL and testbench
==============================

# fpcmp_sched

Round-robin scheduler that shares one `fpcmp` comparison unit among `NREQ` requesters. It accepts predicate and operand requests and latches the winning request's operands. It sequences `fpcmp` through its run/stall handshake and returns `z` and `flags` with a per-requester completion pulse. It sits between the command front-ends (serial test controller, CPU FPU issue logic) and the single `fpcmp` instance.

## Interface
- `NREQ`, default 4: number of requesters, range 2..8.
- `clk`  in  1: system clock, 50 MHz.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req`  in  NREQ: request per requester. Held high until `ack`.
- `req_pred`  in  2*NREQ: predicate of requester i at bits [2i+1:2i].
- `req_x`  in  32*NREQ: operand x of requester i at bits [32i+31:32i].
- `req_y`  in  32*NREQ: operand y, same packing as `req_x`.
- `ack`  out  NREQ: one-hot, 1-cycle. Marks the cycle the operands are latched.
- `done`  out  NREQ: one-hot, 1-cycle. Marks the cycle `res_z`/`res_flags` are valid for that requester.
- `res_z`  out  1: comparison result. Held until the next completion.
- `res_flags`  out  5: exception flags. Held until the next completion.
- `busy`  out  1: high in any state other than IDLE.
- `fp_run`  out  1: to `fpcmp.run`.
- `fp_stall`  in  1: from `fpcmp.stall`.
- `fp_pred`  out  2: to `fpcmp.pred`.
- `fp_x`  out  32: to `fpcmp.x`.
- `fp_y`  out  32: to `fpcmp.y`.
- `fp_z`  in  1: from `fpcmp.z`.
- `fp_flags`  in  5: from `fpcmp.flags`.

## Operation
- The FSM has three states: IDLE, BUSY and DONE.
- **IDLE**
  - If `req` is nonzero, pick the winner by round-robin: search from index `last+1` upward, wrapping modulo NREQ.
  - Assert `ack[winner]` combinationally in the same cycle.
  - Latch the winner's pred/x/y into `fp_pred`/`fp_x`/`fp_y` and store `owner` = winner. Go to BUSY.
  - If `req` is zero, stay in IDLE with `ack` = 0.
- **BUSY**
  - `fp_run` = 1. Operand registers are stable for the whole state.
  - If `fp_stall` = 1, stay in BUSY.
  - If `fp_stall` = 0, capture `fp_z`/`fp_flags` into `res_z`/`res_flags` and go to DONE.
- **DONE**
  - `fp_run` = 0 and `done[owner]` = 1. Update `last` <= `owner`. Go to IDLE.
- Requests are not queued.
  - A `req` that drops before its `ack` is dropped silently.
  - A `req` still high after its `ack` is a new request and competes again in the next IDLE cycle.
- Fairness: with all requesters continuously requesting, the grant order is 0,1,…,NREQ-1,0,…
- Operand changes on `req_*` after `ack` have no effect on the operation in flight.
- Reset, including mid-BUSY:
  - State goes to IDLE and `last` = NREQ-1, so requester 0 has first priority.
  - `ack`, `done`, `fp_run`, `busy`, `res_z`, `res_flags`, `fp_pred`, `fp_x`, `fp_y` and `owner` are all 0.
  - An operation aborted by reset produces no `done`.

## Timing
- `ack` is Mealy: it rises in the cycle IDLE sees `req`.
- `fp_run` is Moore: it is registered from state.
- Minimum latency from the `ack` cycle to the `done` cycle is 2 cycles: ack at t, BUSY at t+1 with stall = 0, DONE at t+2.
- Each stall cycle adds 1 cycle of latency.
- Minimum throughput is one operation per 3 cycles. The next `ack` can occur at t+3.
- `res_z`/`res_flags` change only on the clock edge entering DONE and are stable in the `done` cycle and afterwards.
- `busy` = (state != IDLE), registered.

## Structure
- Shared include `fpcmp_defs.vh` holds:
  - state encodings: IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2; encoding 3 recovers to IDLE with all outputs inactive.
  - predicate codes shared with `fpcmp`.
- One sub-module, `rr_pick`:
  - combinational round-robin picker;
  - inputs: `req[NREQ]`, `last` index;
  - outputs: one-hot `grant` and `grant_idx`.
- Everything else lives in `fpcmp_sched`.
- The bench uses a behavioural `fpcmp` model with a programmable stall count.

## Test plan
- Single requester, 0 stall cycles:
  - stimulus: reset, then `req[2]`=1, pred=1, x=0x3F800000, y=0x40000000 at t;
  - response: `ack`=0b0100 at t, `fp_run` at t+1, `done`=0b0100 at t+2, `res_z`=1 (x<y), `res_flags`=0.
- Stall of 3 cycles:
  - stimulus: one request with the `fpcmp` model asserting stall for 3 cycles;
  - response: `fp_run` high for 4 cycles, `done` 5 cycles after `ack`, operands constant throughout.
- All 4 requesting continuously after reset:
  - response: `ack` sequence 0001, 0010, 0100, 1000, 0001, spaced 3 cycles apart.
- Simultaneous requests 0 and 3 after requester 0 was last served:
  - response: 3 is granted first, then 0.
- NaN operand:
  - stimulus: x=0x7FC00000, y=0, pred=2;
  - response: `res_z`=0, `res_flags`=model value (invalid bit set), delivered on the correct `done` bit.
- Reset mid-operation:
  - stimulus: drop `rst_n` during BUSY with stall held;
  - response: `fp_run`, `busy`, `res_*` go to 0 asynchronously, no `done` pulse, and the next grant goes to requester 0.

Source files
------------

// File: rtl/fpcmp_sched_pkg.sv
// ============================================================================
// Module      : fpcmp_sched_pkg
// Description : Shared state encodings, predicate codes and widths for the
//               fpcmp round-robin scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fpcmp_sched_pkg;

  // Scheduler state encoding; ST_BAD is unreachable and recovers to idle
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_BAD  = 2'd3;

  // Predicate codes understood by fpcmp
  localparam logic [1:0] PRED_EQ = 2'd0;  // quiet equal
  localparam logic [1:0] PRED_LT = 2'd1;  // signaling less-than
  localparam logic [1:0] PRED_LE = 2'd2;  // signaling less-or-equal
  localparam logic [1:0] PRED_UN = 2'd3;  // unordered

  localparam int OP_W   = 32;
  localparam int FLAG_W = 5;

  // Index width needed to name one of n requesters (n >= 2)
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fpcmp_sched_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Searches upward from the
//               index after `last`, wrapping modulo NREQ, and returns the
//               first active request as one-hot grant plus its index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
  import fpcmp_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx
);

  logic          w_found;
  logic [IW-1:0] w_cand;

  // Walk the NREQ candidates in priority order and keep the first hit
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      // last < NREQ, so last+k < 2*NREQ and one subtraction wraps it
      if ((int'(last) + k) >= NREQ) begin
        w_cand = IW'(int'(last) + k - NREQ);
      end else begin
        w_cand = IW'(int'(last) + k);
      end
      if (!w_found && req[w_cand]) begin
        w_found         = 1'b1;
        grant[w_cand]   = 1'b1;
        grant_idx       = w_cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fpcmp_sched.sv
// ============================================================================
// Module      : fpcmp_sched
// Description : Round-robin scheduler sharing one fpcmp comparison unit among
//               NREQ requesters. Latches the winner's operands, sequences
//               fpcmp through run/stall and returns z/flags with a one-hot
//               completion pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpcmp_sched
  import fpcmp_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    req_pred,
  input  logic [32*NREQ-1:0]   req_x,
  input  logic [32*NREQ-1:0]   req_y,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      done,
  output logic                 res_z,
  output logic [FLAG_W-1:0]    res_flags,
  output logic                 busy,
  output logic                 fp_run,
  input  logic                 fp_stall,
  output logic [1:0]           fp_pred,
  output logic [OP_W-1:0]      fp_x,
  output logic [OP_W-1:0]      fp_y,
  input  logic                 fp_z,
  input  logic [FLAG_W-1:0]    fp_flags
);

  localparam int IW = idx_width(NREQ);

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [IW-1:0]   r_last;
  logic [IW-1:0]   r_owner;
  logic            r_fp_run;
  logic            r_busy;
  logic            r_res_z;
  logic [FLAG_W-1:0] r_res_flags;
  logic [1:0]      r_fp_pred;
  logic [OP_W-1:0] r_fp_x;
  logic [OP_W-1:0] r_fp_y;

  logic [NREQ-1:0] w_grant;
  logic [IW-1:0]   w_grant_idx;
  logic            w_any_req;
  logic            w_take;
  logic            w_finish;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req       (req),
    .last      (r_last),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  assign w_any_req = |req;
  // A grant happens in the idle cycle that sees any request
  assign w_take    = (r_state == ST_IDLE) && w_any_req;
  // The operation completes on the first busy cycle without stall
  assign w_finish  = (r_state == ST_BUSY) && !fp_stall;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; the unused encoding falls back to idle
  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE: w_state_nxt = w_any_req ? ST_BUSY : ST_IDLE;
      ST_BUSY: w_state_nxt = fp_stall ? ST_BUSY : ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: Mealy ack in idle, Moore done pulse in the done state
  always_comb begin
    ack  = '0;
    done = '0;
    case (r_state)
      ST_IDLE: begin
        // Gated by reset so no grant is shown while the block is held
        if (rst_n && w_any_req) begin
          ack = w_grant;
        end
      end
      ST_DONE: done = NREQ'(1) << r_owner;
      default: begin
        ack  = '0;
        done = '0;
      end
    endcase
  end

  // Registered run/busy derived from the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fp_run <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_fp_run <= (w_state_nxt == ST_BUSY);
      r_busy   <= (w_state_nxt != ST_IDLE);
    end
  end

  // Operand and owner capture on grant; held stable for the whole operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fp_pred <= '0;
      r_fp_x    <= '0;
      r_fp_y    <= '0;
      r_owner   <= '0;
    end else if (w_take) begin
      r_fp_pred <= req_pred[{w_grant_idx, 1'b0} +: 2];
      r_fp_x    <= req_x[{w_grant_idx, 5'd0} +: OP_W];
      r_fp_y    <= req_y[{w_grant_idx, 5'd0} +: OP_W];
      r_owner   <= w_grant_idx;
    end
  end

  // Result capture on the edge entering done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_z     <= 1'b0;
      r_res_flags <= '0;
    end else if (w_finish) begin
      r_res_z     <= fp_z;
      r_res_flags <= fp_flags;
    end
  end

  // Round-robin pointer: reset makes requester 0 the first candidate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= IW'(NREQ - 1);
    end else if (r_state == ST_DONE) begin
      r_last <= r_owner;
    end
  end

  assign fp_run    = r_fp_run;
  assign busy      = r_busy;
  assign fp_pred   = r_fp_pred;
  assign fp_x      = r_fp_x;
  assign fp_y      = r_fp_y;
  assign res_z     = r_res_z;
  assign res_flags = r_res_flags;

endmodule

`default_nettype wire

// File: tb/tb_fpcmp_sched.sv
// ============================================================================
// Module      : tb_fpcmp_sched
// Description : Self-checking bench for fpcmp_sched with a behavioural fpcmp
//               (programmable stall) and a transaction-level scheduler model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpcmp_sched;
  import fpcmp_sched_pkg::*;

  localparam int N = 4;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [2*N-1:0]  req_pred;
  logic [32*N-1:0] req_x;
  logic [32*N-1:0] req_y;
  logic [N-1:0]    ack;
  logic [N-1:0]    done;
  logic            res_z;
  logic [4:0]      res_flags;
  logic            busy;
  logic            fp_run;
  logic            fp_stall;
  logic [1:0]      fp_pred;
  logic [31:0]     fp_x;
  logic [31:0]     fp_y;
  logic            fp_z;
  logic [4:0]      fp_flags;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;
  int stall_prog = 0;

  fpcmp_sched #(.NREQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_pred  (req_pred),
    .req_x     (req_x),
    .req_y     (req_y),
    .ack       (ack),
    .done      (done),
    .res_z     (res_z),
    .res_flags (res_flags),
    .busy      (busy),
    .fp_run    (fp_run),
    .fp_stall  (fp_stall),
    .fp_pred   (fp_pred),
    .fp_x      (fp_x),
    .fp_y      (fp_y),
    .fp_z      (fp_z),
    .fp_flags  (fp_flags)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // IEEE single compare; flags are {NV,DZ,OF,UF,NX}; returns {z, flags}
  function automatic logic [5:0] fcmp(input logic [1:0] p, input logic [31:0] a, input logic [31:0] b);
    logic an, bn, asn, bsn, nv, z, bothz, eq, lt;
    an    = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn    = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    asn   = an && !a[22];
    bsn   = bn && !b[22];
    if (an || bn) begin
      nv = (p == PRED_LT) || (p == PRED_LE) || asn || bsn;
      z  = (p == PRED_UN);
      return {z, nv, 4'b0};
    end
    bothz = (a[30:0] == 0) && (b[30:0] == 0);
    eq    = bothz || (a == b);
    if (eq)                lt = 1'b0;
    else if (a[31] != b[31]) lt = a[31];
    else if (!a[31])       lt = a[30:0] < b[30:0];
    else                   lt = a[30:0] > b[30:0];
    case (p)
      PRED_EQ: z = eq;
      PRED_LT: z = lt;
      PRED_LE: z = lt || eq;
      default: z = 1'b0;
    endcase
    return {z, 5'b0};
  endfunction

  // Behavioural fpcmp: result is a pure function of the operands, stall is
  // asserted for the first stall_prog cycles of each run
  int st_cnt;
  assign {fp_z, fp_flags} = fcmp(fp_pred, fp_x, fp_y);
  assign fp_stall = fp_run && (st_cnt < stall_prog);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      st_cnt <= 0;
    else if (fp_run) st_cnt <= st_cnt + 1;
    else             st_cnt <= 0;
  end

  // Round-robin winner from the rule: first requester after `last`, wrapping
  function automatic int rr_win(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return 0;
  endfunction

  // Scheduler model: an operation occupies stall+1 run cycles, then one
  // completion cycle, then the unit is free again
  int          m_last, m_owner, m_run_left;
  bit          m_done;
  logic [1:0]  m_pred;
  logic [31:0] m_x, m_y;
  logic        m_z;
  logic [4:0]  m_f;
  logic        m_idle;
  logic [N-1:0] e_ack;

  assign m_idle = !m_done && (m_run_left == 0);
  assign e_ack  = (rst_n && m_idle && (req != 0)) ? (N'(1) << rr_win(req, m_last)) : '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_last <= N - 1; m_owner <= 0; m_run_left <= 0; m_done <= 0;
      m_pred <= 0; m_x <= 0; m_y <= 0; m_z <= 0; m_f <= 0;
    end else if (m_done) begin
      m_done <= 0;
      m_last <= m_owner;
    end else if (m_run_left > 0) begin
      m_run_left <= m_run_left - 1;
      if (m_run_left == 1) begin
        m_done     <= 1;
        {m_z, m_f} <= fcmp(m_pred, m_x, m_y);
      end
    end else if (req != 0) begin
      m_owner    <= rr_win(req, m_last);
      m_pred     <= req_pred[2*rr_win(req, m_last) +: 2];
      m_x        <= req_x[32*rr_win(req, m_last) +: 32];
      m_y        <= req_y[32*rr_win(req, m_last) +: 32];
      m_run_left <= stall_prog + 1;
    end
  end

  // Cycle-by-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("ack", ack, e_ack);
      check("done", done, m_done ? (N'(1) << m_owner) : N'(0));
      check("fp_run", fp_run, m_run_left > 0);
      check("busy", busy, !m_idle);
      check("res_z", res_z, m_z);
      check("res_flags", res_flags, m_f);
      check("fp_pred", fp_pred, m_pred);
      check("fp_x", fp_x, m_x);
      check("fp_y", fp_y, m_y);
    end
  end

  task automatic set_op(input int i, input logic [1:0] p, input logic [31:0] x, input logic [31:0] y);
    req_pred[2*i +: 2] = p;
    req_x[32*i +: 32]  = x;
    req_y[32*i +: 32]  = y;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the next ack at a negedge and check its value
  task automatic wait_ack(input string name, input logic [N-1:0] exp);
    bit seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (ack != 0) seen = 1;
      else step();
    end
    if (seen) check(name, ack, exp);
    else      check({name, "_timeout"}, 0, 1);
  endtask

  logic [N-1:0] exp_seq [7];
  int run_cnt, done_k;

  initial begin
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b1000, 4'b0001};
    rst_n = 1; req = 0; req_pred = 0; req_x = 0; req_y = 0;
    #3 rst_n = 0;
    chk_en = 1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_fp_run", fp_run, 0);
    check("rst_done", done, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // Single requester, no stall: 1.0 < 2.0
    set_op(2, PRED_LT, 32'h3F80_0000, 32'h4000_0000);
    req = 4'b0100;
    wait_ack("t1_ack", 4'b0100);
    step(); req = 0;
    @(negedge clk); check("t1_run", fp_run, 1);
    step();
    @(negedge clk);
    check("t1_done", done, 4'b0100);
    check("t1_z", res_z, 1);
    check("t1_flags", res_flags, 0);
    step();

    // Three stall cycles: four run cycles, done five cycles after ack
    stall_prog = 3;
    set_op(1, PRED_EQ, 32'h4040_0000, 32'h4040_0000);
    req = 4'b0010;
    wait_ack("t2_ack", 4'b0010);
    step(); req = 0; req_x[63:32] = 32'hDEAD_BEEF;
    run_cnt = 0; done_k = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (fp_run) run_cnt++;
      if (done != 0 && done_k == 0) done_k = k;
      if (k == 4) check("t2_fp_x_held", fp_x, 32'h4040_0000);
      step();
    end
    check("t2_run_cycles", run_cnt, 4);
    check("t2_done_latency", done_k, 5);
    check("t2_z", res_z, 1);

    // All four continuously, then 0 and 3 with requester 0 last served
    stall_prog = 0;
    rst_n = 0;
    step();
    rst_n = 1;
    for (int i = 0; i < N; i++) set_op(i, PRED_LE, 32'(i) << 23, 32'h3F80_0000);
    req = 4'b1111;
    for (int c = 0; c < 19; c++) begin
      @(negedge clk);
      if (c % 3 == 0) check("rr_ack", ack, exp_seq[c/3]);
      step();
      if (c == 12) req = 4'b1001;
    end
    req = 0;

    // Quiet NaN under a signaling predicate raises invalid
    set_op(1, PRED_LE, 32'h7FC0_0000, 32'h0000_0000);
    req = 4'b0010;
    wait_ack("t5_ack", 4'b0010);
    step(); req = 0;
    step();
    @(negedge clk);
    check("t5_done", done, 4'b0010);
    check("t5_z", res_z, 0);
    check("t5_flags", res_flags, 5'b10000);
    step();

    // Reset while stalled in BUSY
    stall_prog = 20;
    set_op(2, PRED_LT, 32'hBF80_0000, 32'h3F80_0000);
    req = 4'b0100;
    wait_ack("t6_ack", 4'b0100);
    step(); req = 0;
    @(negedge clk); check("t6_run", fp_run, 1);
    step();
    rst_n = 0;
    #1;
    check("t6_rst_run", fp_run, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_z", res_z, 0);
    check("t6_rst_flags", res_flags, 0);
    check("t6_rst_fp_x", fp_x, 0);
    repeat (2) begin
      @(negedge clk);
      check("t6_no_done", done, 0);
    end
    step();
    rst_n = 1; stall_prog = 0;
    set_op(0, PRED_EQ, 32'h0000_0000, 32'h8000_0000);
    set_op(2, PRED_EQ, 32'h1, 32'h2);
    req = 4'b0101;
    @(negedge clk); check("t6_first_grant", ack, 4'b0001);
    step(); req = 0;
    step();
    @(negedge clk);
    check("t6_done", done, 4'b0001);
    check("t6_z_zero_eq", res_z, 1);
    repeat (3) step();

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
